// File: rtl/dbg_cmd_pkg.sv
// rtl/dbg_cmd_pkg.sv - command class constants and default parameters for dbg_cmd_sync_ctrl
package dbg_cmd_pkg;

  localparam int DATA_W_DEF      = 38;
  localparam int IR_W_DEF        = 2;
  localparam int NUM_BRK_DEF     = 4;
  localparam int SYNC_STAGES_DEF = 2;

  localparam int CLS_OCIMEM    = 0;
  localparam int CLS_TRACE     = 1;
  localparam int CLS_BREAK     = 2;
  localparam int CLS_TRACECTRL = 3;

  // Break channel index width; never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dbg_strobe_sync.sv
// rtl/dbg_strobe_sync.sv - multi-flop strobe synchronizer with rising-edge detect
module dbg_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Flops reset high so a strobe held across reset release is not seen as an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/dbg_cmd_sync_ctrl.sv
// rtl/dbg_cmd_sync_ctrl.sv - JTAG command capture and decode into the clk domain
// Optional statistics counters enabled by DBG_CMD_STATS_EN.
module dbg_cmd_sync_ctrl
  import dbg_cmd_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int IR_W        = IR_W_DEF,
  parameter int NUM_BRK     = NUM_BRK_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vs_uir,
  input  logic                 vs_e1dr,
  input  logic [IR_W-1:0]      ir_in,
  input  logic [DATA_W-1:0]    sr,
  input  logic                 cmd_ack,
  input  logic                 ovr_clr,
  output logic [DATA_W-1:0]    jdo,
  output logic [2**IR_W-1:0]   take_action,
  output logic [2**IR_W-1:0]   take_no_action,
  output logic [NUM_BRK-1:0]   brk_sel,
  output logic                 cmd_pending,
  output logic                 overrun,
  output logic [7:0]           cmd_count,
  output logic [7:0]           ovr_count
);

  localparam int NCLS = 2**IR_W;
  localparam int CH_W = ch_width(NUM_BRK);

  logic              uir_rise, e1dr_rise, ovr_event;
  logic [IR_W-1:0]   ir_q, eff_ir, cls_q;
  logic [DATA_W-1:0] jdo_q;
  logic              valid_q, pending_q, overrun_q;
  logic [NCLS-1:0]   take_action_q, take_action_d, take_no_action_q, take_no_action_d;
  logic [NUM_BRK-1:0] brk_sel_q, brk_sel_d;
  logic [CH_W-1:0]   brk_idx;

  dbg_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
    .clk(clk), .reset(reset), .strobe_i(vs_uir), .rise_o(uir_rise)
  );

  dbg_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_e1dr (
    .clk(clk), .reset(reset), .strobe_i(vs_e1dr), .rise_o(e1dr_rise)
  );

  // A same-cycle update-IR supplies the instruction directly; ir_q is not yet loaded.
  assign eff_ir    = uir_rise ? ir_in : ir_q;
  assign ovr_event = e1dr_rise & pending_q & ~cmd_ack;
  assign brk_idx   = jdo_q[DATA_W-2 -: CH_W];

  always_comb begin
    take_action_d    = '0;
    take_no_action_d = '0;
    brk_sel_d        = '0;
    for (int i = 0; i < NCLS; i++) begin
      if (valid_q && cls_q == IR_W'(i)) begin
        if (jdo_q[DATA_W-1]) take_action_d[i] = 1'b1;
        else                 take_no_action_d[i] = 1'b1;
      end
    end
    // Out-of-range channel indices match no bit, leaving brk_sel all zero.
    if (valid_q && jdo_q[DATA_W-1] && cls_q == IR_W'(CLS_BREAK)) begin
      for (int i = 0; i < NUM_BRK; i++) brk_sel_d[i] = (brk_idx == CH_W'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q             <= '0;
      cls_q            <= '0;
      jdo_q            <= '0;
      valid_q          <= 1'b0;
      pending_q        <= 1'b0;
      overrun_q        <= 1'b0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
      brk_sel_q        <= '0;
    end else begin
      if (uir_rise) ir_q <= ir_in;
      if (e1dr_rise) begin
        jdo_q <= sr;
        cls_q <= eff_ir;
      end
      valid_q          <= e1dr_rise;
      take_action_q    <= take_action_d;
      take_no_action_q <= take_no_action_d;
      brk_sel_q        <= brk_sel_d;
      if (e1dr_rise)    pending_q <= 1'b1;
      else if (cmd_ack) pending_q <= 1'b0;
      if (ovr_event)    overrun_q <= 1'b1;
      else if (ovr_clr) overrun_q <= 1'b0;
    end
  end

`ifdef DBG_CMD_STATS_EN
  logic [7:0] cmd_count_q, ovr_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_count_q <= '0;
      ovr_count_q <= '0;
    end else begin
      if (e1dr_rise && cmd_count_q != 8'hff) cmd_count_q <= cmd_count_q + 8'd1;
      if (ovr_event && ovr_count_q != 8'hff) ovr_count_q <= ovr_count_q + 8'd1;
    end
  end

  assign cmd_count = cmd_count_q;
  assign ovr_count = ovr_count_q;
`else
  assign cmd_count = '0;
  assign ovr_count = '0;
`endif

  assign jdo            = jdo_q;
  assign take_action    = take_action_q;
  assign take_no_action = take_no_action_q;
  assign brk_sel        = brk_sel_q;
  assign cmd_pending    = pending_q;
  assign overrun        = overrun_q;

endmodule

// File: doc/dbg_cmd_sync_ctrl.md
DBG_CMD_SYNC_CTRL -- requirements
Module: dbg_cmd_sync_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 38, width of the captured JTAG data register.
REQ-002 SHALL have parameter IR_W, default 2, JTAG instruction width; number of command classes NCLS = 2**IR_W.
REQ-003 SHALL have parameter NUM_BRK, default 4, number of breakpoint channels (1..16); CH_W = max(1, clog2(NUM_BRK)).
REQ-004 SHALL have parameter SYNC_STAGES, default 2 (min 2), number of synchronizer flops per strobe.
REQ-005 clk  in  1  system clock; the only clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 vs_uir  in  1  update-IR level from the JTAG domain; asynchronous to clk.
REQ-008 vs_e1dr  in  1  exit1-DR level from the JTAG domain; asynchronous to clk.
REQ-009 ir_in  in  IR_W  instruction; stable whenever vs_uir is high.
REQ-010 sr  in  DATA_W  shift register contents; stable whenever vs_e1dr is high.
REQ-011 cmd_ack  in  1  CPU side has consumed the current command.
REQ-012 ovr_clr  in  1  clears the overrun flag.
REQ-013 jdo  out  DATA_W  captured command data.
REQ-014 take_action  out  NCLS  one-hot, one-cycle pulse for an action command of class ir.
REQ-015 take_no_action  out  NCLS  one-hot, one-cycle pulse for a no-action (readback) command.
REQ-016 brk_sel  out  NUM_BRK  one-hot break channel; valid only with take_action[CLS_BREAK].
REQ-017 cmd_pending  out  1  command captured and not yet acknowledged.
REQ-018 overrun  out  1  sticky; a new command arrived while one was still pending.
REQ-019 cmd_count, ovr_count  out  8 each  statistics counters (see Configuration).

Function
REQ-020 Each of vs_uir and vs_e1dr SHALL pass through SYNC_STAGES flops, followed by one history flop; a rise is defined as last stage = 1 and history = 0.
REQ-021 On a uir rise, ir_q SHALL load ir_in.
REQ-022 On an e1dr rise, jdo SHALL load sr; the effective instruction is ir_in if uir also rises in that cycle, otherwise ir_q.
REQ-023 In the cycle after an e1dr rise, exactly one bit of take_action (jdo[DATA_W-1]=1) or of take_no_action (=0) SHALL be high, at the index of the effective instruction; all other cycles are 0.
REQ-024 Latency from vs_e1dr rising to the pulse SHALL be SYNC_STAGES+2 clk edges.
REQ-025 For CLS_BREAK action pulses, brk_sel SHALL be one-hot at index jdo[DATA_W-2 -: CH_W]; an index >= NUM_BRK gives brk_sel = 0 while the take_action pulse is still issued; otherwise brk_sel = 0.
REQ-026 cmd_pending SHALL set on an e1dr rise and clear on cmd_ack; rise and ack in the same cycle leave it 1.
REQ-027 An e1dr rise while cmd_pending=1 without a same-cycle cmd_ack SHALL set overrun; jdo is still overwritten (newest wins).
REQ-028 ovr_clr SHALL clear overrun; a same-cycle overrun event wins (overrun stays 1).
REQ-029 cmd_ack while cmd_pending=0 SHALL be ignored.

Reset
REQ-030 While reset is high: jdo, ir_q, take_action, take_no_action, brk_sel, cmd_pending, overrun and both counters SHALL be 0.
REQ-031 Synchronizer and history flops SHALL reset to 1, so a strobe held high through reset produces no event.
REQ-032 Reset asserted mid-command SHALL abort it; no pulse is issued after release.

Configuration
REQ-033 With DBG_CMD_STATS_EN defined, cmd_count SHALL increment on each e1dr rise and ovr_count on each overrun event; both saturate at 255 and clear only on reset.
REQ-034 Without DBG_CMD_STATS_EN, cmd_count and ovr_count SHALL be constant 0, and no counter flops are generated.

Structure
REQ-035 Package dbg_cmd_pkg SHALL hold the class constants CLS_OCIMEM=0, CLS_TRACE=1, CLS_BREAK=2, CLS_TRACECTRL=3 and the default parameter values.
REQ-036 The strobe synchronizer plus edge detector SHALL be sub-module dbg_strobe_sync (parameter SYNC_STAGES), instantiated twice.

Verification
REQ-037 Defaults, ir_in=2 with vs_uir pulse, then sr={1'b1,2'b10,35'h0} with vs_e1dr pulse -> take_action=4'b0100 for 1 cycle at e1dr+4 edges, brk_sel=4'b0100, jdo=sr, cmd_pending=1.
REQ-038 Same with sr[37]=0 and ir=0 -> take_no_action=4'b0001, brk_sel=0, take_action=0.
REQ-039 Two e1dr pulses with no cmd_ack -> overrun=1, jdo = second sr; ovr_clr -> overrun=0; cmd_count=2 and ovr_count=1 with DBG_CMD_STATS_EN, else 0.
REQ-040 uir and e1dr rising in the same synchronized cycle, ir_q=1, ir_in=3 -> pulse on index 3.
REQ-041 vs_e1dr held high across reset release -> no pulse, cmd_pending=0; reset asserted 2 cycles after an e1dr rise -> no pulse, all outputs 0.
REQ-042 NUM_BRK=3, break index 3 -> take_action[2]=1, brk_sel=3'b000.
